// File: rtl/clk_period_monitor.sv
// Clock/strobe period monitor: measures high and low phase widths of mon_in in clk
// cycles, flags out-of-tolerance periods, tracks lock and detects a stopped clock.
module clk_period_monitor #(
  parameter int CNT_W    = 16,
  parameter int EXP_HIGH = 5,
  parameter int EXP_LOW  = 5,
  parameter int TOL      = 0,
  parameter int LOCK_CNT = 4,
  parameter int TIMEOUT  = 64
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             en,
  input  logic             clr_err,
  input  logic             mon_in,
  output logic [CNT_W-1:0] high_cnt,
  output logic [CNT_W-1:0] low_cnt,
  output logic             meas_valid,
  output logic             period_err,
  output logic             err_sticky,
  output logic             locked,
  output logic             timeout
);

  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    WAIT_EDGE = 2'd1,
    MEAS_HIGH = 2'd2,
    MEAS_LOW  = 2'd3
  } state_t;

  localparam int GW = (LOCK_CNT < 2) ? 1 : $clog2(LOCK_CNT + 1);
  localparam logic [CNT_W:0]   EXP_H_V = (CNT_W + 1)'(EXP_HIGH);
  localparam logic [CNT_W:0]   EXP_L_V = (CNT_W + 1)'(EXP_LOW);
  localparam logic [CNT_W:0]   TOL_V   = (CNT_W + 1)'(TOL);
  localparam logic [CNT_W-1:0] TMO_V   = CNT_W'(TIMEOUT);
  localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};
  localparam logic [GW-1:0]    LOCK_V  = GW'(LOCK_CNT);

  state_t            state;
  state_t            state_nxt;
  logic              sync1;
  logic              mon_s;
  logic              mon_d;
  logic              rise;
  logic              fall;
  logic [CNT_W-1:0]  cnt;
  logic [GW-1:0]     good_cnt;
  logic              cap_high;
  logic              cap_low;
  logic              tmo_hit;
  logic              bad_period;

  function automatic logic [CNT_W:0] abs_diff(input logic [CNT_W:0] a, input logic [CNT_W:0] b);
    return (a >= b) ? (a - b) : (b - a);
  endfunction

  assign rise = mon_s & ~mon_d;
  assign fall = ~mon_s & mon_d;

  // The low width is still in cnt on the closing rise; high_cnt was captured at the fall.
  assign bad_period = (abs_diff({1'b0, high_cnt}, EXP_H_V) > TOL_V) ||
                      (abs_diff({1'b0, cnt}, EXP_L_V) > TOL_V);

  // State register.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // Next-state and per-cycle control strobes; disable overrides everything.
  always_comb begin
    state_nxt = state;
    cap_high  = 1'b0;
    cap_low   = 1'b0;
    tmo_hit   = 1'b0;
    if (!en) begin
      state_nxt = IDLE;
    end else if (state != IDLE && cnt == TMO_V && !rise && !fall) begin
      tmo_hit   = 1'b1;
      state_nxt = WAIT_EDGE;
    end else begin
      case (state)
        IDLE:      state_nxt = WAIT_EDGE;
        WAIT_EDGE: if (rise) state_nxt = MEAS_HIGH; else state_nxt = WAIT_EDGE;
        MEAS_HIGH: begin
          if (fall) begin
            cap_high  = 1'b1;
            state_nxt = MEAS_LOW;
          end else begin
            state_nxt = MEAS_HIGH;
          end
        end
        MEAS_LOW: begin
          if (rise) begin
            cap_low   = 1'b1;
            state_nxt = MEAS_HIGH;
          end else begin
            state_nxt = MEAS_LOW;
          end
        end
        default:   state_nxt = IDLE;
      endcase
    end
  end

  // Synchronizer, phase counter, measurement registers and lock/timeout tracking.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      sync1      <= 1'b0;
      mon_s      <= 1'b0;
      mon_d      <= 1'b0;
      cnt        <= '0;
      good_cnt   <= '0;
      high_cnt   <= '0;
      low_cnt    <= '0;
      meas_valid <= 1'b0;
      period_err <= 1'b0;
      err_sticky <= 1'b0;
      locked     <= 1'b0;
      timeout    <= 1'b0;
    end else begin
      sync1      <= mon_in;
      mon_s      <= sync1;
      mon_d      <= mon_s;
      meas_valid <= 1'b0;
      period_err <= 1'b0;

      if (state == IDLE || rise || fall) begin
        cnt <= CNT_W'(1);
      end else if (cnt != CNT_MAX) begin
        cnt <= cnt + CNT_W'(1);
      end

      if (!en) begin
        good_cnt <= '0;
        locked   <= 1'b0;
        timeout  <= 1'b0;
      end else if (tmo_hit) begin
        good_cnt <= '0;
        locked   <= 1'b0;
        timeout  <= 1'b1;
      end else begin
        if (rise) begin
          timeout <= 1'b0;
        end
        if (cap_high) begin
          high_cnt <= cnt;
        end
        if (cap_low) begin
          low_cnt    <= cnt;
          meas_valid <= 1'b1;
          period_err <= bad_period;
          if (bad_period) begin
            good_cnt <= '0;
            locked   <= 1'b0;
          end else begin
            if (good_cnt != LOCK_V) begin
              good_cnt <= good_cnt + GW'(1);
            end
            locked <= (good_cnt >= LOCK_V - GW'(1));
          end
        end
      end

      // A new error wins over a simultaneous clear.
      if (cap_low && bad_period) begin
        err_sticky <= 1'b1;
      end else if (clr_err) begin
        err_sticky <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_clk_period_monitor.sv
// Self-checking bench for clk_period_monitor: table-driven periods with a scoreboard
// of expected measurements, plus hand sequences for clear, timeout, disable and reset.
module tb_clk_period_monitor;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        en;
  logic        clr_err;
  logic        mon_in;
  logic [15:0] high_cnt;
  logic [15:0] low_cnt;
  logic        meas_valid;
  logic        period_err;
  logic        err_sticky;
  logic        locked;
  logic        timeout;

  always #5 clk = ~clk;

  clk_period_monitor dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .en         (en),
    .clr_err    (clr_err),
    .mon_in     (mon_in),
    .high_cnt   (high_cnt),
    .low_cnt    (low_cnt),
    .meas_valid (meas_valid),
    .period_err (period_err),
    .err_sticky (err_sticky),
    .locked     (locked),
    .timeout    (timeout)
  );

  typedef struct {
    int high_w;
    int low_w;
    bit glitch;
    bit exp_err;
    bit exp_locked;
  } vec_t;

  typedef struct {
    int h;
    int l;
    bit err;
    bit lck;
  } exp_t;

  exp_t sb[$];
  int   total = 0;
  int   bad   = 0;

  task automatic check(input string name, input int act, input int req);
    total++;
    if (act != req) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d", name, act, req);
    end
  endtask

  task automatic wait_neg(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic push(input int h, input int l, input bit e, input bit k);
    exp_t x;
    x.h = h;
    x.l = l;
    x.err = e;
    x.lck = k;
    sb.push_back(x);
  endtask

  // One high phase then one low phase; measured when the next rise arrives.
  task automatic drive_period(input int h, input int l, input bit g, input bit e, input bit k);
    mon_in = 1'b1;
    wait_neg(h);
    mon_in = 1'b0;
    if (g && l >= 2) begin
      wait_neg(1);
      #1 mon_in = 1'b1;
      #2 mon_in = 1'b0;
      wait_neg(l - 1);
    end else begin
      wait_neg(l);
    end
    push(h, l, e, k);
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, "_high_cnt"}, int'(high_cnt), 0);
    check({tag, "_low_cnt"}, int'(low_cnt), 0);
    check({tag, "_meas_valid"}, int'(meas_valid), 0);
    check({tag, "_period_err"}, int'(period_err), 0);
    check({tag, "_err_sticky"}, int'(err_sticky), 0);
    check({tag, "_locked"}, int'(locked), 0);
    check({tag, "_timeout"}, int'(timeout), 0);
  endtask

  vec_t tbl[14];

  initial begin
    tbl[0]  = '{5, 5, 1'b0, 1'b0, 1'b0};
    tbl[1]  = '{5, 5, 1'b0, 1'b0, 1'b0};
    tbl[2]  = '{5, 5, 1'b0, 1'b0, 1'b0};
    tbl[3]  = '{5, 5, 1'b0, 1'b0, 1'b1};
    tbl[4]  = '{7, 5, 1'b0, 1'b1, 1'b0};
    tbl[5]  = '{5, 5, 1'b0, 1'b0, 1'b0};
    tbl[6]  = '{5, 5, 1'b1, 1'b0, 1'b0};
    tbl[7]  = '{5, 5, 1'b0, 1'b0, 1'b0};
    tbl[8]  = '{5, 5, 1'b0, 1'b0, 1'b1};
    tbl[9]  = '{5, 3, 1'b0, 1'b1, 1'b0};
    tbl[10] = '{4, 5, 1'b0, 1'b1, 1'b0};
    tbl[11] = '{5, 6, 1'b0, 1'b1, 1'b0};
    tbl[12] = '{1, 1, 1'b0, 1'b1, 1'b0};
    tbl[13] = '{5, 5, 1'b0, 1'b0, 1'b0};

    rst_n   = 1'b0;
    en      = 1'b0;
    clr_err = 1'b0;
    mon_in  = 1'b0;

    fork
      forever begin
        exp_t x;
        @(negedge clk);
        if (meas_valid === 1'b1) begin
          if (sb.size() == 0) begin
            total++;
            bad++;
            $display("FAIL unexpected_meas_valid: got high=%0d low=%0d expected none", high_cnt, low_cnt);
          end else begin
            x = sb.pop_front();
            check("meas_high_cnt", int'(high_cnt), x.h);
            check("meas_low_cnt", int'(low_cnt), x.l);
            check("meas_period_err", int'(period_err), int'(x.err));
            check("meas_locked", int'(locked), int'(x.lck));
            if (x.err) check("meas_err_sticky", int'(err_sticky), 1);
          end
        end
      end
    join_none

    wait_neg(3);
    check_all_zero("reset");
    rst_n = 1'b1;
    wait_neg(2);
    en = 1'b1;
    wait_neg(4);

    for (int i = 0; i < 14; i++) begin
      drive_period(tbl[i].high_w, tbl[i].low_w, tbl[i].glitch, tbl[i].exp_err, tbl[i].exp_locked);
    end
    check("err_sticky_after_errors", int'(err_sticky), 1);

    // Bad period whose evaluation cycle coincides with clr_err.
    drive_period(6, 5, 1'b0, 1'b1, 1'b0);
    mon_in = 1'b1;
    wait_neg(2);
    clr_err = 1'b1;
    wait_neg(1);
    clr_err = 1'b0;
    check("clr_same_cycle_meas_valid", int'(meas_valid), 1);
    check("clr_same_cycle_err_sticky", int'(err_sticky), 1);
    wait_neg(2);
    mon_in = 1'b0;
    wait_neg(2);
    clr_err = 1'b1;
    wait_neg(1);
    clr_err = 1'b0;
    check("clr_alone_err_sticky", int'(err_sticky), 0);
    wait_neg(2);
    push(5, 5, 1'b0, 1'b0);
    drive_period(5, 5, 1'b0, 1'b0, 1'b0);
    drive_period(5, 5, 1'b0, 1'b0, 1'b0);
    drive_period(5, 5, 1'b0, 1'b0, 1'b1);

    // Clock stops low after lock.
    mon_in = 1'b1;
    wait_neg(5);
    mon_in = 1'b0;
    begin
      int n;
      n = 0;
      while (timeout !== 1'b1 && n < 200) begin
        wait_neg(1);
        n++;
      end
      check("timeout_latency", n, 67);
    end
    check("timeout_locked", int'(locked), 0);
    check("timeout_err_sticky", int'(err_sticky), 0);
    mon_in = 1'b1;
    wait_neg(2);
    check("timeout_held_before_rise", int'(timeout), 1);
    wait_neg(1);
    check("timeout_cleared_by_rise", int'(timeout), 0);
    wait_neg(2);
    mon_in = 1'b0;
    wait_neg(5);
    push(5, 5, 1'b0, 1'b0);
    drive_period(5, 5, 1'b0, 1'b0, 1'b0);

    // Disable in the middle of a high phase.
    mon_in = 1'b1;
    wait_neg(4);
    en = 1'b0;
    wait_neg(1);
    mon_in = 1'b0;
    wait_neg(6);
    check("idle_locked", int'(locked), 0);
    check("idle_high_hold", int'(high_cnt), 5);
    check("idle_low_hold", int'(low_cnt), 5);
    mon_in = 1'b1;
    wait_neg(5);
    mon_in = 1'b0;
    wait_neg(5);
    check("idle_no_err", int'(err_sticky), 0);
    en = 1'b1;
    wait_neg(4);
    drive_period(5, 5, 1'b0, 1'b0, 1'b0);
    drive_period(5, 5, 1'b0, 1'b0, 1'b0);

    // Reset in the middle of a low phase.
    mon_in = 1'b1;
    wait_neg(5);
    mon_in = 1'b0;
    wait_neg(2);
    rst_n = 1'b0;
    wait_neg(1);
    rst_n = 1'b1;
    check_all_zero("midrst");
    wait_neg(10);
    check("scoreboard_drained", sb.size(), 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
